// File: rtl/register_dump_unit_pkg.sv
// Shared widths, dump FSM encoding and beat payload for the register dump unit.
package register_dump_unit_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DATA_W     = 32;

  // Dump FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } dump_state_t;

  // One {index, value} beat as it appears on the debug stream
  typedef struct packed {
    logic [REG_ADDR_W-1:0] index;
    logic [DATA_W-1:0]     data;
  } beat_t;

endpackage

// File: rtl/register_dump_unit_if.sv
// Valid/ready beat stream from the dump unit to the debug/trace link.
interface register_dump_unit_if #(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [SIZE-1:0]   out_data;

  // Producer side (dump unit)
  modport master (
    output out_valid,
    output out_index,
    output out_data,
    input  out_ready
  );

  // Consumer side (trace link)
  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/register_dump_unit.sv
// Walks the register bank read port r0..r(NREGS-1) and streams each register
// as one {index, value} beat. Read-only with respect to the bank.
module register_dump_unit
  import register_dump_unit_pkg::*;
#(
  parameter int unsigned SIZE   = DATA_W,
  parameter int unsigned NREGS  = NUM_REGS,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [SIZE-1:0]             rd_data,
  register_dump_unit_if.master        stream,
  output logic                        busy,
  output logic                        done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;

  // The bank read address is the walk counter itself
  assign rd_addr = idx;

  // Dump FSM, walk counter and beat holding registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      stream.out_valid <= 1'b0;
      stream.out_index <= '0;
      stream.out_data  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Abort wins over any handshake in the same cycle; no done follows
        state            <= ST_IDLE;
        idx              <= '0;
        stream.out_valid <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              idx   <= '0;
              busy  <= 1'b1;
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            stream.out_data  <= rd_data;
            stream.out_index <= idx;
            stream.out_valid <= 1'b1;
            state            <= ST_SEND;
          end
          ST_SEND: begin
            if (stream.out_valid && stream.out_ready) begin
              stream.out_valid <= 1'b0;
              if (idx == LAST_IDX) begin
                // Last beat taken: no increment, so idx never wraps
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                idx   <= idx + ADDR_W'(1);
                state <= ST_CAPTURE;
              end
            end
          end
          ST_DONE: begin
            idx   <= '0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
